// File: rtl/dram_burst_reader_if.sv
// Request, return-data and Avalon-MM read-master bundle of dram_burst_reader.
// READ_CHECKSUM exists only when DRAM_BURST_READER_CHECKSUM_EN is defined.
interface dram_burst_reader_if #(
  parameter int MAXBURST_LOG   = 4,
  parameter int READNUM_SIZE   = 32,
  parameter int DRAM_ADDRSPACE = 64,
  parameter int DRAM_DATAWIDTH = 512
);
  // Handshakes: READ_REQ is taken only in a cycle with READ_RDY=1; a return beat
  // is consumed in any cycle where READ_DATA_VALID && READ_DATA_READY; an Avalon
  // command is accepted in a cycle where AVALON_MM_READ && !AVALON_MM_WAITREQUEST.
  logic                        READ_REQ;
  logic [DRAM_ADDRSPACE-1:0]   READ_INITADDR;
  logic [READNUM_SIZE:0]       READ_NUM;
  logic                        READ_RDY;
  logic                        READ_REQ_DONE;
  logic [DRAM_DATAWIDTH-1:0]   READ_DATA;
  logic                        READ_DATA_VALID;
  logic                        READ_DATA_READY;
  logic [DRAM_DATAWIDTH-1:0]   AVALON_MM_READDATA;
  logic                        AVALON_MM_READDATAVALID;
  logic                        AVALON_MM_WAITREQUEST;
  logic                        AVALON_MM_WRITEACK;
  logic [DRAM_ADDRSPACE-1:0]   AVALON_MM_ADDRESS;
  logic                        AVALON_MM_READ;
  logic                        AVALON_MM_WRITE;
  logic [DRAM_DATAWIDTH-1:0]   AVALON_MM_WRITEDATA;
  logic [DRAM_DATAWIDTH/8-1:0] AVALON_MM_BYTEENABLE;
  logic [MAXBURST_LOG:0]       AVALON_MM_BURSTCOUNT;
`ifdef DRAM_BURST_READER_CHECKSUM_EN
  logic [31:0]                 READ_CHECKSUM;
`endif

  modport master (
    input  READ_REQ, READ_INITADDR, READ_NUM, READ_DATA_READY,
    input  AVALON_MM_READDATA, AVALON_MM_READDATAVALID, AVALON_MM_WAITREQUEST,
    input  AVALON_MM_WRITEACK,
    output READ_RDY, READ_REQ_DONE, READ_DATA, READ_DATA_VALID,
    output AVALON_MM_ADDRESS, AVALON_MM_READ, AVALON_MM_WRITE, AVALON_MM_WRITEDATA,
    output AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
`ifdef DRAM_BURST_READER_CHECKSUM_EN
    , output READ_CHECKSUM
`endif
  );

  modport slave (
    output READ_REQ, READ_INITADDR, READ_NUM, READ_DATA_READY,
    output AVALON_MM_READDATA, AVALON_MM_READDATAVALID, AVALON_MM_WAITREQUEST,
    output AVALON_MM_WRITEACK,
    input  READ_RDY, READ_REQ_DONE, READ_DATA, READ_DATA_VALID,
    input  AVALON_MM_ADDRESS, AVALON_MM_READ, AVALON_MM_WRITE, AVALON_MM_WRITEDATA,
    input  AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
`ifdef DRAM_BURST_READER_CHECKSUM_EN
    , input READ_CHECKSUM
`endif
  );
endinterface

// File: rtl/dram_burst_reader.sv
// Avalon-MM burst read master feeding a show-ahead return FIFO with credit-based issue.
// Optional running checksum of popped beats: define DRAM_BURST_READER_CHECKSUM_EN.
module dram_burst_reader #(
  parameter int MAXBURST_LOG   = 4,
  parameter int READNUM_SIZE   = 32,
  parameter int DRAM_ADDRSPACE = 64,
  parameter int DRAM_DATAWIDTH = 512,
  parameter int FIFO_DEPTH_LOG = 6
) (
  input  logic                CLK,
  input  logic                RST,
  dram_burst_reader_if.master bus,
  output logic [1:0]          dbg_state
);
  localparam int BYTES = DRAM_DATAWIDTH / 8;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int OW    = FIFO_DEPTH_LOG + 1;
  localparam int CW    = FIFO_DEPTH_LOG + 2;
  localparam int NW    = READNUM_SIZE + 1;
  localparam logic [MAXBURST_LOG:0]     MAX_BURST = {1'b1, {MAXBURST_LOG{1'b0}}};
  localparam logic [DRAM_ADDRSPACE-1:0] ADDR_STEP = DRAM_ADDRSPACE'(BYTES) << MAXBURST_LOG;
  localparam logic [NW-1:0]             ONE_N     = NW'(1);

  if ((1 << FIFO_DEPTH_LOG) < (2 << MAXBURST_LOG)) begin : g_depth_check
    $error("FIFO_DEPTH_LOG must hold at least two maximum bursts");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, CMD, DRAIN} state_t;

  state_t                    state;
  logic [DRAM_ADDRSPACE-1:0] address;
  logic [NW-1:0]             burstnum;
  logic [MAXBURST_LOG:0]     last_burst;
  logic [NW-1:0]             beats_left;
  logic [OW-1:0]             outstanding;
  logic [MAXBURST_LOG:0]     burst_q;
  logic                      read_q;
  logic                      done_q;

  logic [DRAM_DATAWIDTH-1:0] mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [OW-1:0]             fifo_count;

  logic                      push;
  logic                      pop;
  logic                      accept;
  logic [MAXBURST_LOG:0]     next_burst;
  logic                      credit_ok;
  logic [MAXBURST_LOG-1:0]   req_rem;
  logic [OW-1:0]             out_next;
  logic                      unused_writeack;

  assign unused_writeack = bus.AVALON_MM_WRITEACK;

  // Beats landing while idle belong to an abandoned request and are dropped.
  assign push       = bus.AVALON_MM_READDATAVALID && (state != IDLE);
  assign pop        = bus.READ_DATA_VALID && bus.READ_DATA_READY;
  assign accept     = (state == CMD) && !bus.AVALON_MM_WAITREQUEST;
  assign req_rem    = bus.READ_NUM[MAXBURST_LOG-1:0];
  assign next_burst = (burstnum == ONE_N) ? last_burst : MAX_BURST;

  // Every beat already stored or still owed must fit alongside the new burst,
  // which is why Avalon never needs backpressure on the return path.
  assign credit_ok = (CW'(fifo_count) + CW'(outstanding) + CW'(next_burst)) <= CW'(DEPTH);

  always_comb begin
    out_next = outstanding;
    if (accept) out_next = out_next + OW'(burst_q);
    if (push)   out_next = out_next - OW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      address     <= '0;
      burstnum    <= '0;
      last_burst  <= '0;
      beats_left  <= '0;
      outstanding <= '0;
      burst_q     <= '0;
      read_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      outstanding <= out_next;
      if (pop && (beats_left != '0)) beats_left <= beats_left - ONE_N;
      case (state)
        IDLE: begin
          if (bus.READ_REQ) begin
            address    <= bus.READ_INITADDR;
            burstnum   <= (bus.READ_NUM >> MAXBURST_LOG) + ((req_rem != '0) ? ONE_N : '0);
            last_burst <= (req_rem == '0) ? MAX_BURST : {1'b0, req_rem};
            beats_left <= bus.READ_NUM;
            state      <= (bus.READ_NUM == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            burst_q <= next_burst;
            read_q  <= 1'b1;
            state   <= CMD;
          end
        end
        CMD: begin
          if (accept) begin
            read_q   <= 1'b0;
            address  <= address + ADDR_STEP;
            burstnum <= burstnum - ONE_N;
            state    <= (burstnum > ONE_N) ? ISSUE : DRAIN;
          end
        end
        DRAIN: begin
          // One cycle of DONE with the FIFO already empty, then back to idle.
          if (done_q) begin
            state <= IDLE;
          end else if (beats_left == '0) begin
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.AVALON_MM_READDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + OW'(1);
        2'b01:   fifo_count <= fifo_count - OW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef DRAM_BURST_READER_CHECKSUM_EN
  logic [31:0] checksum;

  always_ff @(posedge CLK) begin
    if (RST) begin
      checksum <= '0;
    end else if ((state == IDLE) && bus.READ_REQ) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + bus.READ_DATA[31:0];
    end
  end

  assign bus.READ_CHECKSUM = checksum;
`endif

  assign bus.READ_RDY             = (state == IDLE);
  assign bus.READ_REQ_DONE        = done_q;
  assign bus.READ_DATA            = mem[rd_ptr];
  assign bus.READ_DATA_VALID      = (fifo_count != '0);
  assign bus.AVALON_MM_ADDRESS    = address;
  assign bus.AVALON_MM_READ       = read_q;
  assign bus.AVALON_MM_BURSTCOUNT = burst_q;
  assign bus.AVALON_MM_WRITE      = 1'b0;
  assign bus.AVALON_MM_WRITEDATA  = '0;
  assign bus.AVALON_MM_BYTEENABLE = '1;
  assign dbg_state                = state;
endmodule

// File: tb/tb_dram_burst_reader.sv
// Scoreboard bench for dram_burst_reader: Avalon slave memory model, random pop pressure,
// expected beat/command queues built from the request rules.
`timescale 1ns/1ps
module tb_dram_burst_reader;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int ML = 4;
  localparam int NS = 32;
  localparam int FDL = 6;
  localparam int BEAT_BYTES = DW / 8;
  localparam int MAXB = 1 << ML;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [1:0] dbg_state;
  int total = 0;
  int bad = 0;

  dram_burst_reader_if #(.MAXBURST_LOG(ML), .READNUM_SIZE(NS), .DRAM_ADDRSPACE(AW),
                         .DRAM_DATAWIDTH(DW)) bus ();

  dram_burst_reader #(.MAXBURST_LOG(ML), .READNUM_SIZE(NS), .DRAM_ADDRSPACE(AW),
                      .DRAM_DATAWIDTH(DW), .FIFO_DEPTH_LOG(FDL)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .dbg_state(dbg_state));

  // ---------------- clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state
  logic [DW-1:0]   exp_q[$];
  logic [AW+ML:0]  cmd_q[$];
  logic [31:0]     sum_q[$];
  logic [DW-1:0]   ret_q[$];
  int              ret_due_q[$];
  logic [31:0]     mem_ovr[logic [63:0]];
  int pending_done = 0;
  int done_seen = 0;
  int ready_mode = 1;
  int wait_mode = 0;
  int hold_cnt = 0;
  int lat_base = 1;
  int beats_cmd = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected none", name, val);
  endtask

  // Memory contents seen by the Avalon slave: a per-address pattern unless overridden.
  function automatic logic [DW-1:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[37:6] ^ a[63:32] ^ 32'h5A17_C3E9;
    if (mem_ovr.exists(a)) lo = mem_ovr[a];
    mem_word = {a, {13{lo ^ 32'h0F0F_0F0F}}, lo};
  endfunction

  // ---------------- Avalon slave model
  logic          held_v = 1'b0;
  logic [AW-1:0] held_a;
  logic [ML:0]   held_b;
  logic          wr;

  initial begin
    bus.AVALON_MM_WAITREQUEST   = 1'b0;
    bus.AVALON_MM_READDATAVALID = 1'b0;
    bus.AVALON_MM_READDATA      = '0;
    bus.AVALON_MM_WRITEACK      = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (ret_q.size() > 0 && cyc >= ret_due_q[0] && $urandom_range(0, 3) != 0) begin
        bus.AVALON_MM_READDATAVALID = 1'b1;
        bus.AVALON_MM_READDATA      = ret_q.pop_front();
        ret_due_q.delete(0);
      end else begin
        bus.AVALON_MM_READDATAVALID = 1'b0;
        bus.AVALON_MM_READDATA      = '0;
      end
      case (wait_mode)
        1:       wr = ($urandom_range(0, 2) == 0);
        2:       wr = bus.AVALON_MM_READ && (hold_cnt < 5);
        default: wr = 1'b0;
      endcase
      bus.AVALON_MM_WAITREQUEST = wr;
      if (held_v && !RST) begin
        check("cmd_hold_read", bus.AVALON_MM_READ, 1'b1);
        check("cmd_hold_addr", bus.AVALON_MM_ADDRESS, held_a);
        check("cmd_hold_burst", bus.AVALON_MM_BURSTCOUNT, held_b);
      end
      held_v = 1'b0;
      if (bus.AVALON_MM_READ) begin
        if (wait_mode == 2 && wr) hold_cnt++;
        if (!wr) begin
          beats_cmd += int'(bus.AVALON_MM_BURSTCOUNT);
          for (int j = 0; j < int'(bus.AVALON_MM_BURSTCOUNT); j++) begin
            ret_q.push_back(mem_word(bus.AVALON_MM_ADDRESS + 64'(j) * BEAT_BYTES));
            ret_due_q.push_back(cyc + lat_base + $urandom_range(0, 2));
          end
          if (!RST) begin
            if (cmd_q.size() == 0) fail_now("cmd_unexpected", int'(bus.AVALON_MM_BURSTCOUNT));
            else check("cmd", {bus.AVALON_MM_ADDRESS, bus.AVALON_MM_BURSTCOUNT}, cmd_q.pop_front());
          end
        end else begin
          held_v = !RST;
          held_a = bus.AVALON_MM_ADDRESS;
          held_b = bus.AVALON_MM_BURSTCOUNT;
        end
      end
    end
  end

  // ---------------- user-side pop driver and monitor
  logic          rdy;
  logic [DW-1:0] e;

  initial begin
    bus.READ_DATA_READY = 1'b0;
    forever begin
      @(negedge CLK);
      case (ready_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      bus.READ_DATA_READY = rdy;
      if (!RST && bus.READ_DATA_VALID && rdy) begin
        if (exp_q.size() == 0) begin
          fail_now("beat_unexpected", int'(bus.READ_DATA[31:0]));
        end else begin
          e = exp_q.pop_front();
          check("beat", bus.READ_DATA, e);
        end
      end
      if (!RST && bus.READ_REQ_DONE) begin
        if (pending_done == 0) begin
          fail_now("done_unexpected", done_seen);
        end else begin
          pending_done--;
          done_seen++;
          check("done_beats_left", exp_q.size(), 0);
          check("done_vs_valid", bus.READ_DATA_VALID, 1'b0);
`ifdef DRAM_BURST_READER_CHECKSUM_EN
          if (sum_q.size() > 0) check("checksum", bus.READ_CHECKSUM, sum_q.pop_front());
`endif
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic issue(input logic [63:0] a, input int n);
    int t;
    int rem;
    int k;
    int b;
    logic [31:0]   s;
    logic [DW-1:0] w;
    t = 0;
    @(negedge CLK);
    while (!bus.READ_RDY && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.READ_RDY) begin
      fail_now("rdy_timeout", t);
      return;
    end
    s = '0;
    for (int i = 0; i < n; i++) begin
      w = mem_word(a + 64'(i) * BEAT_BYTES);
      exp_q.push_back(w);
      s = s + w[31:0];
    end
    rem = n;
    k = 0;
    while (rem > 0) begin
      b = (rem > MAXB) ? MAXB : rem;
      cmd_q.push_back({a + 64'(k) * (MAXB * BEAT_BYTES), 5'(b)});
      rem -= b;
      k++;
    end
    sum_q.push_back(s);
    pending_done++;
    bus.READ_INITADDR = a;
    bus.READ_NUM      = 33'(n);
    bus.READ_REQ      = 1'b1;
    @(negedge CLK);
    bus.READ_REQ = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    exp_q.delete();
    cmd_q.delete();
    sum_q.delete();
    pending_done = 0;
    repeat (n) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (pending_done > 0 && t < budget) begin
      @(negedge CLK);
      t++;
    end
    total++;
    if (pending_done > 0) begin
      bad++;
      $display("FAIL done_timeout: pending=%0d after %0d cycles expected 0", pending_done, t);
      apply_reset(2);
    end
    check("cmds_all_issued", cmd_q.size(), 0);
  endtask

  // ---------------- test sequence
  int base;
  int t;

  initial begin
    bus.READ_REQ      = 1'b0;
    bus.READ_INITADDR = '0;
    bus.READ_NUM      = '0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_rdy", bus.READ_RDY, 1'b1);
    check("rst_done", bus.READ_REQ_DONE, 1'b0);
    check("rst_valid", bus.READ_DATA_VALID, 1'b0);
    check("rst_read", bus.AVALON_MM_READ, 1'b0);
    check("rst_write", bus.AVALON_MM_WRITE, 1'b0);
    check("rst_wdata", bus.AVALON_MM_WRITEDATA, '0);
    check("rst_byteen", bus.AVALON_MM_BYTEENABLE, {(DW/8){1'b1}});
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single full burst, then a multi-burst request with a short tail.
    ready_mode = 1;
    issue(64'h1000, 16);
    wait_done(500);
    issue(64'h0, 37);
    wait_done(500);

    // Zero-length request: DONE two cycles after the request, idle one cycle later.
    issue(64'h9000, 0);
    check("zero_c1_rdy", bus.READ_RDY, 1'b0);
    check("zero_c1_done", bus.READ_REQ_DONE, 1'b0);
    @(negedge CLK);
    check("zero_c2_done", bus.READ_REQ_DONE, 1'b1);
    check("zero_c2_rdy", bus.READ_RDY, 1'b0);
    @(negedge CLK);
    check("zero_c3_rdy", bus.READ_RDY, 1'b1);
    check("zero_c3_done", bus.READ_REQ_DONE, 1'b0);
    wait_done(10);

    // Credit limit: nothing popped, so issue must stop once the FIFO is spoken for.
    ready_mode = 0;
    base = beats_cmd;
    issue(64'h20000, 256);
    repeat (300) @(negedge CLK);
    check("credit_beats", beats_cmd - base, 64);
    check("credit_read_stopped", bus.AVALON_MM_READ, 1'b0);
    check("credit_valid", bus.READ_DATA_VALID, 1'b1);
    ready_mode = 1;
    wait_done(3000);

    // Waitrequest held on the first command, plus an ignored mid-transfer request.
    hold_cnt = 0;
    wait_mode = 2;
    ready_mode = 2;
    issue(64'h5000, 20);
    @(negedge CLK);
    check("busy_rdy", bus.READ_RDY, 1'b0);
    bus.READ_INITADDR = 64'hDEAD_0000;
    bus.READ_NUM      = 33'd7;
    bus.READ_REQ      = 1'b1;
    @(negedge CLK);
    bus.READ_REQ = 1'b0;
    wait_done(1000);
    wait_mode = 0;

    // Reset mid-transfer with late beats still in flight.
    ready_mode = 0;
    lat_base = 25;
    base = beats_cmd;
    issue(64'h40000, 64);
    t = 0;
    while (beats_cmd - base < 32 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    apply_reset(2);
    t = 0;
    while ((ret_q.size() > 0 || t < 10) && t < 400) begin
      @(negedge CLK);
      check("post_rst_valid", bus.READ_DATA_VALID, 1'b0);
      t++;
    end
    check("post_rst_rdy", bus.READ_RDY, 1'b1);
    lat_base = 1;
    ready_mode = 1;

    // Address wrap across the top of the address space.
    wait_mode = 1;
    ready_mode = 2;
    issue(64'hFFFF_FFFF_FFFF_F800, 40);
    wait_done(2000);

    // Randomized requests.
    for (int r = 0; r < 12; r++) begin
      wait_mode  = $urandom_range(0, 1);
      ready_mode = $urandom_range(1, 2);
      issue({$urandom, $urandom}, $urandom_range(0, 80));
      wait_done(4000);
    end
    wait_mode = 0;
    ready_mode = 1;

`ifdef DRAM_BURST_READER_CHECKSUM_EN
    mem_ovr[64'h7000] = 32'h1;
    mem_ovr[64'h7040] = 32'h2;
    mem_ovr[64'h7080] = 32'h3;
    mem_ovr[64'h70C0] = 32'hFFFF_FFFF;
    issue(64'h7000, 4);
    wait_done(500);
    repeat (3) @(negedge CLK);
    check("checksum_stable", bus.READ_CHECKSUM, 32'h0000_0005);
`endif

    repeat (5) @(negedge CLK);
    check("final_exp_empty", exp_q.size(), 0);
    check("final_rdy", bus.READ_RDY, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
